// File: rtl/axis_write_pkg.sv
// Shared state encoding and width helpers for the AXI write-data packer.
package axis_write_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_LOAD   = 4'b0010,
    S_ACTIVE = 4'b0100,
    S_FLUSH  = 4'b1000
  } state_t;

  function automatic int strb_width(input int data_width, input int width_ratio);
    return (data_width * width_ratio) / 8;
  endfunction

endpackage

// File: rtl/axis_pack_strb.sv
// Packs input words into little-endian AXI beats with byte strobes, then
// presents them through an output register backed by a one-entry skid slot.
module axis_pack_strb #(
  parameter int DATA_WIDTH     = 32,
  parameter int WIDTH_RATIO    = 2,
  parameter int AXI_DATA_WIDTH = DATA_WIDTH * WIDTH_RATIO,
  parameter int STRB_WIDTH     = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clear,
  input  logic                      i_word_vld,
  input  logic [DATA_WIDTH-1:0]     i_word,
  input  logic                      i_word_final,
  input  logic                      i_beat_last,
  output logic                      o_beat_rdy,
  output logic                      o_beat_push,
  output logic                      o_drain_hs,
  output logic [AXI_DATA_WIDTH-1:0] o_wdata,
  output logic [STRB_WIDTH-1:0]     o_wstrb,
  output logic                      o_wlast,
  output logic                      o_wvalid,
  input  logic                      i_wready
);

  localparam int LW    = (WIDTH_RATIO > 1) ? $clog2(WIDTH_RATIO) : 1;
  localparam int BYTES = DATA_WIDTH / 8;

  logic [LW-1:0]             r_lane;
  logic [AXI_DATA_WIDTH-1:0] r_acc;
  logic [STRB_WIDTH-1:0]     r_strb_acc;
  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0]     w_strb;
  logic                      w_lane_full;
  logic [AXI_DATA_WIDTH-1:0] r_skid_data;
  logic [STRB_WIDTH-1:0]     r_skid_strb;
  logic                      r_skid_last;
  logic                      r_skid_vld;

  assign w_lane_full = (r_lane == LW'(WIDTH_RATIO - 1));
  assign o_beat_push = i_word_vld && (w_lane_full || i_word_final);
  assign w_data = r_acc | (AXI_DATA_WIDTH'(i_word) << (int'(r_lane) * DATA_WIDTH));
  assign w_strb = r_strb_acc | (STRB_WIDTH'({BYTES{1'b1}}) << (int'(r_lane) * BYTES));
  // New beats are only accepted while the skid slot is free, so nothing is lost on a stall.
  assign o_beat_rdy = !r_skid_vld;
  assign o_drain_hs = o_wvalid && i_wready && !r_skid_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_strb_acc <= '0;
      r_lane     <= '0;
    end else if (i_clear || o_beat_push) begin
      r_acc      <= '0;
      r_strb_acc <= '0;
      r_lane     <= '0;
    end else if (i_word_vld) begin
      r_acc      <= w_data;
      r_strb_acc <= w_strb;
      r_lane     <= r_lane + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wdata     <= '0;
      o_wstrb     <= '0;
      o_wlast     <= 1'b0;
      o_wvalid    <= 1'b0;
      r_skid_data <= '0;
      r_skid_strb <= '0;
      r_skid_last <= 1'b0;
      r_skid_vld  <= 1'b0;
    end else if (!o_wvalid || i_wready) begin
      if (r_skid_vld) begin
        o_wdata    <= r_skid_data;
        o_wstrb    <= r_skid_strb;
        o_wlast    <= r_skid_last;
        o_wvalid   <= 1'b1;
        r_skid_vld <= 1'b0;
      end else if (o_beat_push) begin
        o_wdata  <= w_data;
        o_wstrb  <= w_strb;
        o_wlast  <= i_beat_last;
        o_wvalid <= 1'b1;
      end else begin
        o_wvalid <= 1'b0;
      end
    end else if (o_beat_push) begin
      r_skid_data <= w_data;
      r_skid_strb <= w_strb;
      r_skid_last <= i_beat_last;
      r_skid_vld  <= 1'b1;
    end
  end

endmodule

// File: rtl/fifo_simple.sv
// Show-ahead synchronous FIFO; occupancy is exported and full/empty derive from it.
module fifo_simple #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_dout,
  output logic [AW:0]   o_count
);

  logic [DW-1:0] r_mem [2**AW];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_full;
  logic          w_empty;

  assign o_count = r_wptr - r_rptr;
  assign w_full  = o_count[AW];
  assign w_empty = (r_wptr == r_rptr);
  assign o_dout  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (i_push && !w_full) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push && !w_full) r_wptr <= r_wptr + (AW+1)'(1);
      if (i_pop && !w_empty) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/axis_write_data_strb.sv
// Turns a word stream plus queued stream lengths into AXI write-data beats
// with strobes, burst-aligned wlast and an end-of-stream done pulse.
module axis_write_data_strb
  import axis_write_pkg::*;
#(
  parameter int CFG_DWIDTH     = 32,
  parameter int BUF_CFG_AWIDTH = 5,
  parameter int BUF_AWIDTH     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int WIDTH_RATIO    = 2,
  parameter int BURST_LEN      = 256,
  localparam int AXI_DATA_WIDTH = DATA_WIDTH * WIDTH_RATIO,
  localparam int STRB_WIDTH     = strb_width(DATA_WIDTH, WIDTH_RATIO)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CFG_DWIDTH-1:0]     cfg_length,
  input  logic                      cfg_val,
  output logic                      cfg_rdy,
  output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
  output logic [STRB_WIDTH-1:0]     axi_wstrb,
  output logic                      axi_wlast,
  output logic                      axi_wvalid,
  input  logic                      axi_wready,
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic                      valid,
  output logic                      ready,
  output logic                      done,
  output logic                      busy
);

  // state    | meaning
  // S_IDLE   | waiting for a queued length
  // S_LOAD   | length latched, counters cleared, zero-length shortcut
  // S_ACTIVE | popping and packing words
  // S_FLUSH  | final word packed, waiting for last beat handshake

  state_t                  r_state;
  logic [CFG_DWIDTH-1:0]   r_words_left;
  logic [CFG_DWIDTH-1:0]   r_beat_idx;
  logic                    r_done;
  logic                    r_ready;

  logic [CFG_DWIDTH-1:0]   w_len_dout;
  logic [BUF_CFG_AWIDTH:0] w_len_count;
  logic                    w_len_empty;
  logic                    w_len_pop;
  logic [DATA_WIDTH-1:0]   w_word;
  logic [BUF_AWIDTH:0]     w_word_count;
  logic                    w_word_empty;
  logic                    w_word_push;
  logic                    w_pop;
  logic                    w_final;
  logic                    w_beat_last;
  logic                    w_beat_rdy;
  logic                    w_beat_push;
  logic                    w_drain_hs;

  assign cfg_rdy      = !w_len_count[BUF_CFG_AWIDTH];
  assign w_len_empty  = (w_len_count == '0);
  assign w_len_pop    = (r_state == S_IDLE) && !w_len_empty;
  assign w_word_empty = (w_word_count == '0);
  assign w_word_push  = valid && !w_word_count[BUF_AWIDTH];
  assign w_pop        = (r_state == S_ACTIVE) && !w_word_empty && w_beat_rdy;
  assign w_final      = (r_words_left == CFG_DWIDTH'(1));
  assign w_beat_last  = (r_beat_idx == CFG_DWIDTH'(BURST_LEN - 1)) || w_final;
  assign ready        = r_ready;
  assign done         = r_done;
  assign busy         = (r_state != S_IDLE);

  fifo_simple #(.DW(CFG_DWIDTH), .AW(BUF_CFG_AWIDTH)) u_len_fifo (
    .clk(clk), .rst_n(rst_n), .i_push(cfg_val && cfg_rdy), .i_din(cfg_length),
    .i_pop(w_len_pop), .o_dout(w_len_dout), .o_count(w_len_count)
  );

  fifo_simple #(.DW(DATA_WIDTH), .AW(BUF_AWIDTH)) u_word_fifo (
    .clk(clk), .rst_n(rst_n), .i_push(w_word_push), .i_din(data),
    .i_pop(w_pop), .o_dout(w_word), .o_count(w_word_count)
  );

  axis_pack_strb #(
    .DATA_WIDTH(DATA_WIDTH), .WIDTH_RATIO(WIDTH_RATIO),
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH), .STRB_WIDTH(STRB_WIDTH)
  ) u_pack (
    .clk(clk), .rst_n(rst_n), .i_clear(r_state == S_LOAD),
    .i_word_vld(w_pop), .i_word(w_word), .i_word_final(w_final),
    .i_beat_last(w_beat_last), .o_beat_rdy(w_beat_rdy), .o_beat_push(w_beat_push),
    .o_drain_hs(w_drain_hs), .o_wdata(axi_wdata), .o_wstrb(axi_wstrb),
    .o_wlast(axi_wlast), .o_wvalid(axi_wvalid), .i_wready(axi_wready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ready <= 1'b0;
    else        r_ready <= (w_word_count < (BUF_AWIDTH+1)'(2**(BUF_AWIDTH-1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_words_left <= '0;
      r_beat_idx   <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Beat position within the current burst; the stream's final beat also closes a burst.
      if (w_beat_push) r_beat_idx <= w_beat_last ? '0 : r_beat_idx + CFG_DWIDTH'(1);
      unique case (r_state)
        S_IDLE: begin
          if (w_len_pop) begin
            r_words_left <= w_len_dout;
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_beat_idx <= '0;
          if (r_words_left == '0) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (w_pop) begin
            r_words_left <= r_words_left - CFG_DWIDTH'(1);
            if (w_final) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_drain_hs) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
